// File: rtl/mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul_seq_pkg
//   Shared definitions for the execute-stage arithmetic blocks:
//   - adder16 mode encodings (ADD, SUB, PADDSB, RED)
//   - mul_seq sequencer state encodings (3-bit)
//   - small helper used by the packed-byte adder mode
// -----------------------------------------------------------------------------
package mul_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  // Iteration index of the final shift-and-add step (16 iterations, 0..15).
  localparam logic [CNT_W-1:0] LAST_ITER = 4'd15;

  typedef enum logic [1:0] {
    MODE_ADD    = 2'b00,  // signed add, saturating
    MODE_SUB    = 2'b01,  // signed subtract, saturating
    MODE_PADDSB = 2'b10,  // two independent signed byte adds, saturating
    MODE_RED    = 2'b11   // plain wrap-around add, cout is the true carry
  } adder_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABS_A  = 3'd1,
    ST_ABS_B  = 3'd2,
    ST_LOOP   = 3'd3,
    ST_NEG_LO = 3'd4,
    ST_NEG_HI = 3'd5,
    ST_DONE   = 3'd6
  } mul_state_e;

  // Signed 8-bit saturating add; returns {overflow, sum}.
  function automatic logic [8:0] add8_sat(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] s;
    logic       o;
    s = x + y;
    o = (x[7] == y[7]) && (s[7] != x[7]);
    return {o, (o ? (x[7] ? 8'h80 : 8'h7F) : s)};
  endfunction

endpackage

// File: rtl/adder16.sv
// -----------------------------------------------------------------------------
// adder16
//   Purely combinational 16-bit adder shared by execute-stage sequencers.
//   Ports:
//     a, b  : operands
//     mode  : adder_mode_e (ADD / SUB / PADDSB saturate, RED wraps)
//     sum   : result
//     cout  : carry out of bit 15 of the full-width add (true carry in RED)
//     ov    : signed overflow (either byte in PADDSB)
// -----------------------------------------------------------------------------
module adder16
  import mul_seq_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  adder_mode_e mode,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ov
);

  logic [15:0] b_eff;
  logic        cin;
  logic [16:0] full;
  logic [15:0] raw;
  logic        sov;
  logic [8:0]  byte_lo;
  logic [8:0]  byte_hi;

  // SUB reuses the adder as a + ~b + 1.
  assign b_eff = (mode == MODE_SUB) ? ~b : b;
  assign cin   = (mode == MODE_SUB);
  assign full  = {1'b0, a} + {1'b0, b_eff} + {16'b0, cin};
  assign raw   = full[15:0];
  assign sov   = (a[15] == b_eff[15]) && (raw[15] != a[15]);

  assign byte_lo = add8_sat(a[7:0],  b[7:0]);
  assign byte_hi = add8_sat(a[15:8], b[15:8]);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; an incomplete assignment in always_comb would infer a latch.
  always_comb begin
    sum  = raw;
    cout = full[16];
    ov   = sov;
    case (mode)
      MODE_ADD, MODE_SUB: begin
        if (sov) sum = a[15] ? 16'h8000 : 16'h7FFF;
      end
      MODE_PADDSB: begin
        sum = {byte_hi[7:0], byte_lo[7:0]};
        ov  = byte_hi[8] | byte_lo[8];
      end
      default: begin
        sum = raw;
      end
    endcase
  end

endmodule

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
//   Multi-cycle 16x16 -> 32 shift-and-add multiplier that time-shares a single
//   adder16 (always in RED mode). Signed operands are handled by taking
//   magnitudes first (ABS_A/ABS_B) and negating the 32-bit result at the end
//   (NEG_LO/NEG_HI) when the operand signs differ.
//   Latency from the accepting edge: 17 cycles unsigned, 21 cycles signed.
//
//   Parameters:
//     SIGNED_EN : 0 forces every operation to unsigned (sgn ignored)
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     start      : request, accepted only in IDLE
//     sgn        : 1 = two's-complement operands (sampled with start)
//     a, b       : multiplicand / multiplier (sampled with start)
//     busy       : high in every state except IDLE
//     done       : one-cycle pulse, product valid from this cycle on
//     product    : 32-bit result, held until the next accepted start
// -----------------------------------------------------------------------------
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sgn,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mul_state_e       state, state_nxt;
  logic [15:0]      mcand, mcand_nxt;
  logic [15:0]      hi, hi_nxt;
  logic [15:0]      lo, lo_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             neg, neg_nxt;
  logic             signed_op, signed_op_nxt;
  logic             carry, carry_nxt;
  logic             done_nxt;
  logic [31:0]      product_nxt;

  logic [15:0]      add_a, add_b, add_sum;
  logic             add_cout;
  logic             adder_ov_unused;
  logic             sgn_eff;

  assign sgn_eff = SIGNED_EN & sgn;

  adder16 u_adder (
    .a    (add_a),
    .b    (add_b),
    .mode (MODE_RED),
    .sum  (add_sum),
    .cout (add_cout),
    .ov   (adder_ov_unused)
  );

  // Operand muxes in front of the shared adder. Two's-complement negation is
  // ~x + 1; the high half of the 32-bit negate adds the low half's carry.
  always_comb begin
    add_a = 16'h0000;
    add_b = 16'h0000;
    case (state)
      ST_ABS_A: begin
        add_a = ~mcand;
        add_b = 16'h0001;
      end
      ST_ABS_B, ST_NEG_LO: begin
        add_a = ~lo;
        add_b = 16'h0001;
      end
      ST_LOOP: begin
        add_a = hi;
        add_b = lo[0] ? mcand : 16'h0000;
      end
      ST_NEG_HI: begin
        add_a = ~hi;
        add_b = {15'b0, carry};
      end
      default: begin
        add_a = 16'h0000;
        add_b = 16'h0000;
      end
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt     = state;
    mcand_nxt     = mcand;
    hi_nxt        = hi;
    lo_nxt        = lo;
    cnt_nxt       = cnt;
    neg_nxt       = neg;
    signed_op_nxt = signed_op;
    carry_nxt     = carry;
    done_nxt      = 1'b0;
    product_nxt   = product;

    case (state)
      ST_IDLE: begin
        if (start) begin
          mcand_nxt     = a;
          lo_nxt        = b;
          hi_nxt        = 16'h0000;
          cnt_nxt       = '0;
          neg_nxt       = sgn_eff & (a[15] ^ b[15]);
          signed_op_nxt = sgn_eff;
          carry_nxt     = 1'b0;
          state_nxt     = sgn_eff ? ST_ABS_A : ST_LOOP;
        end
      end

      ST_ABS_A: begin
        if (mcand[15]) mcand_nxt = add_sum;
        state_nxt = ST_ABS_B;
      end

      ST_ABS_B: begin
        if (lo[15]) lo_nxt = add_sum;
        state_nxt = ST_LOOP;
      end

      ST_LOOP: begin
        // The carry re-enters at the top of hi as the pair shifts right, so
        // the 17-bit partial sum is never truncated.
        hi_nxt  = {add_cout, add_sum[15:1]};
        lo_nxt  = {add_sum[0], lo[15:1]};
        cnt_nxt = cnt + 4'd1;
        if (cnt == LAST_ITER) begin
          if (signed_op) begin
            state_nxt = ST_NEG_LO;
          end else begin
            // Load the result on the edge entering DONE so product and done
            // are both registered and valid during the DONE cycle.
            state_nxt   = ST_DONE;
            done_nxt    = 1'b1;
            product_nxt = {add_cout, add_sum[15:1], add_sum[0], lo[15:1]};
          end
        end
      end

      ST_NEG_LO: begin
        if (neg) begin
          lo_nxt    = add_sum;
          carry_nxt = add_cout;
        end else begin
          carry_nxt = 1'b0;
        end
        state_nxt = ST_NEG_HI;
      end

      ST_NEG_HI: begin
        if (neg) hi_nxt = add_sum;
        state_nxt   = ST_DONE;
        done_nxt    = 1'b1;
        product_nxt = {(neg ? add_sum : hi), lo};
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the datapath registers are reset too, not just the state, because
  // product must read 0 after reset and stale operands must not survive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mcand     <= 16'h0000;
      hi        <= 16'h0000;
      lo        <= 16'h0000;
      cnt       <= '0;
      neg       <= 1'b0;
      signed_op <= 1'b0;
      carry     <= 1'b0;
      done      <= 1'b0;
      product   <= 32'h0000_0000;
    end else begin
      state     <= state_nxt;
      mcand     <= mcand_nxt;
      hi        <= hi_nxt;
      lo        <= lo_nxt;
      cnt       <= cnt_nxt;
      neg       <= neg_nxt;
      signed_op <= signed_op_nxt;
      carry     <= carry_nxt;
      done      <= done_nxt;
      product   <= product_nxt;
    end
  end

  // Decoded from the state register only, so no input-to-output path.
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_seq
//   Self-checking bench for mul_seq. Two instances: the default signed-capable
//   build and a SIGNED_EN=0 build. Expected products come from plain integer
//   multiplication; expected busy/done follow the fixed per-mode latency.
// -----------------------------------------------------------------------------
module tb_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start_s, start_u;
  logic        sgn;
  logic [15:0] a, b;
  logic        busy_s, done_s, busy_u, done_u;
  logic [31:0] product_s, product_u;

  int checks = 0;
  int errors = 0;

  mul_seq #(.SIGNED_EN(1'b1)) u_dut_s (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s),
    .sgn     (sgn),
    .a       (a),
    .b       (b),
    .busy    (busy_s),
    .done    (done_s),
    .product (product_s)
  );

  mul_seq #(.SIGNED_EN(1'b0)) u_dut_u (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_u),
    .sgn     (sgn),
    .a       (a),
    .b       (b),
    .busy    (busy_u),
    .done    (done_u),
    .product (product_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: ordinary integer product of the operands as interpreted.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                          input logic s);
    int          sx, sy, sp;
    logic [31:0] ux, uy, r;
    if (s) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
      sp = sx * sy;
      r  = sp;
    end else begin
      ux = {16'h0000, x};
      uy = {16'h0000, y};
      r  = ux * uy;
    end
    return r;
  endfunction

  // Called at a negedge: raises start there (sampled at the next rising edge,
  // cycle 0), then walks cycles 1..lat+1 checking busy/done/product. Returns
  // at the negedge of the IDLE cycle after DONE so a caller can start again
  // immediately. With inject set, start is re-pulsed with fresh random
  // operands at cycle 5 and in the DONE cycle; both must be ignored.
  task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic s, input bit on_u, input bit inject);
    int          lat;
    logic        eff_s;
    logic [31:0] exp;
    logic        bsy, dn;
    logic [31:0] prod;
    eff_s = s & ~on_u;
    lat   = eff_s ? 21 : 17;
    exp   = ref_mul(x, y, eff_s);
    a = x; b = y; sgn = s;
    if (on_u) start_u = 1'b1; else start_s = 1'b1;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      start_s = 1'b0;
      start_u = 1'b0;
      if (inject && (k == 5 || k == lat)) begin
        a   = 16'($urandom);
        b   = 16'($urandom);
        sgn = 1'($urandom);
        if (on_u) start_u = 1'b1; else start_s = 1'b1;
      end
      bsy  = on_u ? busy_u    : busy_s;
      dn   = on_u ? done_u    : done_s;
      prod = on_u ? product_u : product_s;
      check($sformatf("%s.busy@%0d", tag, k), {31'b0, bsy}, {31'b0, (k <= lat)});
      check($sformatf("%s.done@%0d", tag, k), {31'b0, dn},  {31'b0, (k == lat)});
      if (k >= lat) check($sformatf("%s.product@%0d", tag, k), prod, exp);
    end
  endtask

  logic [15:0] corners [5];
  logic [15:0] rx, ry;
  logic        rs;
  bit          ru;

  initial begin
    corners = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};
    rst_n = 1'b0; start_s = 1'b0; start_u = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset.busy_s",    {31'b0, busy_s}, 32'd0);
    check("reset.done_s",    {31'b0, done_s}, 32'd0);
    check("reset.product_s", product_s,       32'd0);
    check("reset.busy_u",    {31'b0, busy_u}, 32'd0);
    check("reset.product_u", product_u,       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed unsigned and signed cases.
    do_op("u3x5",       16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0);
    check("u3x5.exact", product_s, 32'h0000_000F);
    do_op("uFFFFxFFFF", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    check("uFFFF.exact", product_s, 32'hFFFE_0001);
    do_op("s-3x7",      16'hFFFD, 16'h0007, 1'b1, 1'b0, 1'b0);
    check("s-3x7.exact", product_s, 32'hFFFF_FFEB);
    do_op("s-1x-1",     16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    check("s-1x-1.exact", product_s, 32'h0000_0001);
    do_op("s8000x8000", 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
    check("s8000x8000.exact", product_s, 32'h4000_0000);
    do_op("s8000x1",    16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("s8000x1.exact", product_s, 32'hFFFF_8000);
    do_op("s0x-5",      16'h0000, 16'hFFFB, 1'b1, 1'b0, 1'b0);
    check("s0x-5.exact", product_s, 32'h0000_0000);

    // Ignored starts at cycles 5 and 17, then a start accepted at cycle 18
    // (done at cycle 35).
    do_op("inject",     16'h0003, 16'h0005, 1'b0, 1'b0, 1'b1);
    do_op("after_inj",  16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a signed multiply (rst_n low at cycle 8).
    a = 16'hFFFD; b = 16'h0007; sgn = 1'b1; start_s = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (k == 8) rst_n = 1'b0;
    end
    @(negedge clk);
    check("midrst.busy",    {31'b0, busy_s}, 32'd0);
    check("midrst.done",    {31'b0, done_s}, 32'd0);
    check("midrst.product", product_s,       32'd0);
    rst_n = 1'b1;
    do_op("rst_u2x2", 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0);
    check("rst_u2x2.exact", product_s, 32'h0000_0004);

    // Unsigned-only build ignores sgn.
    do_op("nosgn-1x-1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    check("nosgn.exact", product_u, 32'hFFFE_0001);

    // Randomized operands, modes and builds, back to back.
    for (int i = 0; i < 24; i++) begin
      rx = (($urandom_range(0, 3)) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      ry = (($urandom_range(0, 3)) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      rs = 1'($urandom);
      ru = (i % 5 == 4);
      do_op($sformatf("rand%0d", i), rx, ry, rs, ru, (i % 7 == 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle 16×16 shift-and-add multiplier sequencer that time-shares one `adder16` instance to produce a 32-bit product. It sits beside the ALU in the execute stage and is started by the decode/control logic for multiply instructions. It holds the pipeline via `busy` until `done`. It supports unsigned and two's-complement signed operands and uses only the adder's non-saturating RED mode.

## Interface
- `SIGNED_EN`, default 1: when 0, `sgn` is ignored and all operations are unsigned; ABS/NEG states are never entered.

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `sgn`  in  1  1 = signed operands; sampled with `start`.
- `a`  in  16  multiplicand; sampled with `start`.
- `b`  in  16  multiplier; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `product` is valid from this cycle on.
- `product`  out  32  result; held until the next accepted `start`.

## Operation
- States: IDLE, ABS_A, ABS_B, LOOP, NEG_LO, NEG_HI, DONE.
- IDLE with `start=1`:
  - Latch `a` → `mcand` and `b` → `lo`; clear `hi`; `cnt=0`.
  - `neg = sgn & (a[15]^b[15])`.
  - Next state is ABS_A if `sgn` (and `SIGNED_EN`), else LOOP.
- Adder usage: every adder operation uses mode 2'b11 (RED), so there is no saturation and `cout` is the true carry.
- ABS_A: if `mcand[15]`, set `mcand = adder(~mcand, 16'h0001)`; otherwise hold. Next state ABS_B.
- ABS_B: same operation on `lo`. Next state LOOP.
- LOOP, one iteration per cycle:
  - Compute `{c,s} = adder(hi, lo[0] ? mcand : 0)`.
  - Update `hi = {c, s[15:1]}` and `lo = {s[0], lo[15:1]}`; increment `cnt`.
  - After the 16th iteration (`cnt==15` in this cycle), go to NEG_LO if signed, else DONE.
- NEG_LO: if `neg`, set `lo = adder(~lo, 16'h0001)` and latch `cout` into `carry`. If `!neg`, hold `lo` and set `carry=0`.
- NEG_HI: if `neg`, set `hi = adder(~hi, {15'b0, carry})`; otherwise hold. Next state DONE.
- DONE: `product = {hi, lo}`; `done=1`; next state IDLE unconditionally.
- `start` in any non-IDLE state, including DONE, is ignored (no queuing).
- Boundary cases:
  - −32768 magnitude: ~0x8000+1 = 0x8000, which is correct as unsigned 32768.
  - 0x8000 × 0x8000 signed gives 0x40000000.
  - Negating 0 gives 0, with `carry=1` propagating into `hi`.
- Reset (`rst_n=0` at a clock edge), in any state including mid-LOOP:
  - State returns to IDLE and the operation is discarded.
  - `busy=0`, `done=0`, `product=0`; internal registers are cleared.

## Timing
- Cycle 0 is the edge at which `start` is sampled high in IDLE.
- Unsigned: LOOP occupies cycles 1–16; DONE is cycle 17. `done=1` and `product` are valid during cycle 17.
- Signed: ABS_A is cycle 1, ABS_B cycle 2, LOOP cycles 3–18, NEG_LO 19, NEG_HI 20, DONE 21.
- Latency is fixed per mode and does not depend on operand values.
- `busy` rises in cycle 1 and falls after DONE; it is low in DONE+1 (IDLE).
- Earliest next start: sampled in the IDLE cycle following DONE.
- `product` and `done` are registered outputs, with no combinational path from inputs.

## Structure
- The shared ALU defines header holds the adder mode encodings (ADD=2'b00, SUB=2'b01, PADDSB=2'b10, RED=2'b11) and the mul_seq state encodings (3-bit).
- Exactly one sub-module: `adder16`, instantiated once with `mode` tied to RED.
- Operand muxes in front of it are selected by state.
- The `ov` output of the adder is unused.

## Test plan
- Unsigned 3×5:
  - `start` with a=0x0003, b=0x0005, sgn=0.
  - Expect `done` at cycle 17 with `product`=0x0000000F, and `busy`=1 during cycles 1–17.
- Unsigned 0xFFFF×0xFFFF → `product`=0xFFFE0001 at cycle 17, checking the carry path.
- Signed results, each with `done` at cycle 21:
  - −3×7 (0xFFFD, 0x0007) → 0xFFFFFFEB.
  - −1×−1 → 0x00000001.
  - 0x8000×0x8000 → 0x40000000.
  - 0x8000×0x0001 → 0xFFFF8000.
  - 0×−5 → 0x00000000.
- `start` pulsed with new operands at cycles 5 and 17 of an operation:
  - Both are ignored and the original result is returned.
  - A new `start` at cycle 18 is accepted, with `done` at cycle 35.
- `rst_n=0` at cycle 8 of a signed multiply:
  - Next cycle shows `busy`=0, `done`=0, `product`=0.
  - A following unsigned 2×2 returns 0x00000004 after 17 cycles.
- `SIGNED_EN=0` build: −1×−1 with sgn=1 → 0xFFFE0001 at cycle 17.
